// File: rtl/mole_game_if.sv
// Signal bundle between the whack-a-mole core and its surroundings (RNG, buttons, display).
// The game side (stimulus, RNG, buttons) is master; the engine is slave.
interface mole_game_if #(
   parameter int N_TGT   = 7,
   parameter int SCORE_W = 8,
   parameter int LEVEL_W = 2
);
   logic               start;
   logic               tick;
   logic [N_TGT-1:0]   btn;
   logic [N_TGT-1:0]   rnd;
   logic [N_TGT-1:0]   target;
   logic [N_TGT-1:0]   lockout;
   logic [SCORE_W-1:0] score;
   logic [LEVEL_W-1:0] level;
   logic [3:0]         misses;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               busy;
   logic               game_over;

   modport master (
      output start, tick, btn, rnd,
      input  target, lockout, score, level, misses,
      input  hit_pulse, miss_pulse, busy, game_over
   );

   modport slave (
      input  start, tick, btn, rnd,
      output target, lockout, score, level, misses,
      output hit_pulse, miss_pulse, busy, game_over
   );
endinterface

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: lights a multi-target pattern per round, collects rising-edge hits,
// and runs tick-gated game/round timers with score, level and miss tracking.
module mole_game_core #(
   parameter int N_TGT      = 7,
   parameter int SCORE_W    = 8,
   parameter int TMR_W      = 16,
   parameter int GAME_TICKS = 60000,
   parameter int ROUND_T0   = 5000,
   parameter int ROUND_STEP = 1000,
   parameter int ROUND_MIN  = 2000,
   parameter int LEVEL_HITS = 5,
   parameter int LEVEL_MAX  = 3,
   parameter int MAX_LIT    = 4,
   parameter int MISS_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   mole_game_if.slave  bus
);

   localparam int LEVEL_W = (LEVEL_MAX < 1) ? 1 : $clog2(LEVEL_MAX + 1);

   localparam logic [TMR_W-1:0]   GAME_LOAD    = TMR_W'(GAME_TICKS);
   localparam logic [LEVEL_W-1:0] LEVEL_TOP    = LEVEL_W'(LEVEL_MAX);
   localparam logic [SCORE_W-1:0] HITS_PER_LVL = SCORE_W'(LEVEL_HITS);
   localparam logic [3:0]         MISS_CAP     = 4'(MISS_LIMIT);

   localparam logic signed [TMR_W+1:0] T0_S   = (TMR_W+2)'(ROUND_T0);
   localparam logic signed [TMR_W+1:0] STEP_S = (TMR_W+2)'(ROUND_STEP);
   localparam logic signed [TMR_W+1:0] MIN_S  = (TMR_W+2)'(ROUND_MIN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_OVER
   } state_t;

   state_t             state, state_nx;
   logic [N_TGT-1:0]   btn_q;
   logic [N_TGT-1:0]   tgt_q;
   logic [N_TGT-1:0]   hit_mask;
   logic [N_TGT-1:0]   lock_q;
   logic [SCORE_W-1:0] score_q;
   logic [LEVEL_W-1:0] level_q;
   logic [3:0]         misses_q;
   logic [TMR_W-1:0]   game_cnt;
   logic [TMR_W-1:0]   round_cnt;
   logic               hit_p;
   logic               miss_p;

   logic [N_TGT-1:0]   rise;
   logic [N_TGT-1:0]   hits_now;
   logic               in_wait;
   logic               complete;
   logic               expire;
   logic               game_end;
   logic               miss_stop;
   logic               level_up;
   logic [SCORE_W-1:0] score_inc;
   logic [3:0]         misses_inc;

   function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
      return (&s) ? s : s + SCORE_W'(1);
   endfunction

   function automatic logic [3:0] sat_inc_miss(input logic [3:0] m);
      return (&m) ? m : m + 4'd1;
   endfunction

   // Signed, two bits wider than the timer so a large level*step cannot wrap below the floor.
   function automatic logic [TMR_W-1:0] round_load(input logic [LEVEL_W-1:0] lvl);
      logic signed [TMR_W+1:0] lvl_s;
      logic signed [TMR_W+1:0] dur;
      lvl_s = signed'((TMR_W+2)'(lvl));
      dur   = T0_S - lvl_s * STEP_S;
      if (dur < MIN_S) return MIN_S[TMR_W-1:0];
      return dur[TMR_W-1:0];
   endfunction

   function automatic int lit_count(input logic [LEVEL_W-1:0] lvl);
      int n;
      n = int'(lvl) + 1;
      if (n > MAX_LIT) n = MAX_LIT;
      return n;
   endfunction

   // Take lowest-index random bits first, then pad with lowest-index clear bits.
   function automatic logic [N_TGT-1:0] pick_pattern(input logic [N_TGT-1:0] r, input int nl);
      logic [N_TGT-1:0] p;
      int               c;
      p = '0;
      c = 0;
      for (int i = 0; i < N_TGT; i++) begin
         if (r[i] && (c < nl)) begin
            p[i] = 1'b1;
            c++;
         end
      end
      for (int i = 0; i < N_TGT; i++) begin
         if (!p[i] && (c < nl)) begin
            p[i] = 1'b1;
            c++;
         end
      end
      return p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      in_wait    = (state == S_WAIT);
      rise       = bus.btn & ~btn_q & ~lock_q;
      hits_now   = hit_mask | (rise & tgt_q);
      complete   = in_wait && (hits_now == tgt_q);
      expire     = in_wait && !complete && (round_cnt == '0);
      game_end   = in_wait && (game_cnt == '0);
      score_inc  = sat_inc_score(score_q);
      misses_inc = sat_inc_miss(misses_q);
      miss_stop  = (MISS_LIMIT != 0) && (misses_inc == MISS_CAP);
      level_up   = (score_inc != '0) && ((score_inc % HITS_PER_LVL) == '0) &&
                   (level_q < LEVEL_TOP);
      case (state)
         S_IDLE, S_OVER: if (bus.start) state_nx = S_ARM;
         S_ARM:          state_nx = S_WAIT;
         S_WAIT: begin
            if (complete)      state_nx = game_end ? S_OVER : S_ARM;
            else if (expire)   state_nx = (game_end || miss_stop) ? S_OVER : S_ARM;
            else if (game_end) state_nx = S_OVER;
         end
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q     <= '0;
         tgt_q     <= '0;
         hit_mask  <= '0;
         lock_q    <= '0;
         score_q   <= '0;
         level_q   <= '0;
         misses_q  <= '0;
         game_cnt  <= GAME_LOAD;
         round_cnt <= '0;
         hit_p     <= 1'b0;
         miss_p    <= 1'b0;
      end else begin
         btn_q  <= bus.btn;
         hit_p  <= 1'b0;
         miss_p <= 1'b0;
         case (state)
            S_IDLE, S_OVER: begin
               if (bus.start) begin
                  score_q  <= '0;
                  level_q  <= '0;
                  misses_q <= '0;
                  game_cnt <= GAME_LOAD;
               end
            end
            S_ARM: begin
               tgt_q     <= pick_pattern(bus.rnd, lit_count(level_q));
               hit_mask  <= '0;
               lock_q    <= '0;
               round_cnt <= round_load(level_q);
               if (bus.tick && (game_cnt != '0)) game_cnt <= game_cnt - TMR_W'(1);
            end
            S_WAIT: begin
               if (bus.tick) begin
                  if (game_cnt != '0)  game_cnt  <= game_cnt - TMR_W'(1);
                  if (round_cnt != '0) round_cnt <= round_cnt - TMR_W'(1);
               end
               // Any way out of the round drops the per-round masks.
               if (complete || expire || game_end) begin
                  hit_mask <= '0;
                  lock_q   <= '0;
               end else begin
                  hit_mask <= hits_now;
                  lock_q   <= lock_q | (rise & ~tgt_q);
               end
               if (complete) begin
                  score_q <= score_inc;
                  hit_p   <= 1'b1;
                  if (level_up) level_q <= level_q + LEVEL_W'(1);
               end else if (expire) begin
                  misses_q <= misses_inc;
                  miss_p   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.target     = (state == S_WAIT) ? tgt_q : '0;
   assign bus.lockout    = lock_q;
   assign bus.score      = score_q;
   assign bus.level      = level_q;
   assign bus.misses     = misses_q;
   assign bus.hit_pulse  = hit_p;
   assign bus.miss_pulse = miss_p;
   assign bus.busy       = (state == S_ARM) || (state == S_WAIT);
   assign bus.game_over  = (state == S_OVER);

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core: a default-parameter instance for the round/level/miss
// behaviour and a short-timer instance for the same-cycle hit/expire/game-end corner.
module tb_mole_game_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mole_game_if #(.N_TGT(7), .SCORE_W(8), .LEVEL_W(2)) g ();
   mole_game_if #(.N_TGT(7), .SCORE_W(8), .LEVEL_W(2)) g6 ();

   mole_game_core dut (.clk(clk), .rst_n(rst_n), .bus(g));

   mole_game_core #(.GAME_TICKS(9), .ROUND_T0(8), .ROUND_STEP(1), .ROUND_MIN(2)) dut6 (
      .clk(clk), .rst_n(rst_n), .bus(g6)
   );

   int checks = 0;
   int failures = 0;
   int exp_score = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wait(input string tag);
      int n;
      n = 0;
      while (!(g.busy && (g.target != '0)) && (n < 20)) begin
         step();
         n++;
      end
      check(tag, 32'(g.busy && (g.target != '0)), 1);
   endtask

   function automatic int exp_level(input int s);
      return (s / 5 > 3) ? 3 : s / 5;
   endfunction

   task automatic win_round();
      wait_wait("win_wait");
      g.btn = g.target;
      step();
      g.btn = '0;
      exp_score++;
      check("win_hit_pulse", 32'(g.hit_pulse), 1);
      check("win_score", 32'(g.score), 32'(exp_score));
      check("win_level", 32'(g.level), 32'(exp_level(exp_score)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      g.start = 1'b0; g.tick = 1'b0; g.btn = '0; g.rnd = '0;
      g6.start = 1'b0; g6.tick = 1'b0; g6.btn = '0; g6.rnd = '0;
      repeat (3) step();
      check("rst_target", 32'(g.target), 0);
      check("rst_score", 32'(g.score), 0);
      check("rst_flags", {g.busy, g.game_over, g.hit_pulse, g.miss_pulse}, 0);
      check("rst_game_cnt", 32'(dut.game_cnt), 60000);
      check("rst_round_cnt", 32'(dut.round_cnt), 0);
      rst_n = 1'b1;
      step();

      // T1: single lit target, one press completes the round
      g.rnd = 7'b0000100;
      g.start = 1'b1;
      step();
      g.start = 1'b0;
      check("t1_arm_busy", 32'(g.busy), 1);
      check("t1_arm_target", 32'(g.target), 0);
      step();
      check("t1_target", 32'(g.target), 32'(7'b0000100));
      g.btn = 7'b0000100;
      g.rnd = 7'b0000001;
      step();
      g.btn = '0;
      check("t1_hit_pulse", 32'(g.hit_pulse), 1);
      check("t1_score", 32'(g.score), 1);
      check("t1_rearm_target", 32'(g.target), 0);
      step();
      check("t3_target", 32'(g.target), 32'(7'b0000001));
      check("t3_lockout_clear", 32'(g.lockout), 0);

      // T3: wrong press locks that button for the rest of the round
      g.btn = 7'b0100000;
      step();
      check("t3_lockout", 32'(g.lockout), 32'(7'b0100000));
      g.btn = '0;
      step();
      g.btn = 7'b0100000;
      step();
      check("t3_lockout_held", 32'(g.lockout), 32'(7'b0100000));
      check("t3_no_hit", 32'(g.hit_pulse), 0);
      check("t3_score_held", 32'(g.score), 1);
      g.tick = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!g.miss_pulse && (n < 6000));
      check("t3_expire_cycles", 32'(n), 5001);
      check("t3_misses", 32'(g.misses), 1);
      check("t3_lockout_after", 32'(g.lockout), 0);
      check("t3_arm_target", 32'(g.target), 0);

      // T4: two more unanswered rounds reach the miss limit
      g.btn = '0;
      for (int k = 2; k <= 3; k++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (!g.miss_pulse && (n < 6000));
         check("t4_expire_cycles", 32'(n), 5002);
         check("t4_misses", 32'(g.misses), 32'(k));
      end
      check("t4_game_over", 32'(g.game_over), 1);
      check("t4_busy", 32'(g.busy), 0);
      check("t4_target", 32'(g.target), 0);
      g.btn = 7'b0000001;
      step();
      step();
      g.btn = '0;
      check("over_score_held", 32'(g.score), 1);
      check("over_still_over", 32'(g.game_over), 1);

      // Restart from OVER clears score/level/misses
      g.tick = 1'b0;
      g.rnd = 7'b0101010;
      g.start = 1'b1;
      step();
      g.start = 1'b0;
      check("restart_busy", 32'(g.busy), 1);
      check("restart_over", 32'(g.game_over), 0);
      check("restart_stats", {g.score, 2'(g.level), g.misses}, 0);
      exp_score = 0;

      // T5/T2: level progression, lit count and round duration
      repeat (5) win_round();
      wait_wait("t5_wait_l1");
      check("t5_round_l1", 32'(dut.round_cnt), 4000);
      check("t5_target_l1", 32'(g.target), 32'(7'b0001010));
      repeat (5) win_round();
      g.rnd = '0;
      wait_wait("t2_wait");
      check("t2_target", 32'(g.target), 32'(7'b0000111));
      check("t2_round_l2", 32'(dut.round_cnt), 3000);
      g.btn = 7'b0000001;
      step();
      g.btn = '0;
      check("t2_no_hit0", 32'(g.hit_pulse), 0);
      step();
      g.btn = 7'b0000010;
      step();
      g.btn = '0;
      check("t2_no_hit1", 32'(g.hit_pulse), 0);
      check("t2_score_mid", 32'(g.score), 10);
      step();
      g.btn = 7'b0000100;
      step();
      g.btn = '0;
      exp_score = 11;
      check("t2_hit", 32'(g.hit_pulse), 1);
      check("t2_score", 32'(g.score), 11);
      repeat (4) win_round();
      wait_wait("t5_wait_l3");
      check("t5_round_l3", 32'(dut.round_cnt), 2000);
      check("t5_target_l3", 32'(g.target), 32'(7'b0001111));
      repeat (5) win_round();
      check("t5_level_cap", 32'(g.level), 3);

      // T6: final hit on the cycle both timers reach zero
      g6.rnd = 7'b0000001;
      g6.tick = 1'b1;
      g6.start = 1'b1;
      step();
      g6.start = 1'b0;
      step();
      check("t6_round_start", 32'(dut6.round_cnt), 8);
      repeat (8) step();
      check("t6_round_zero", 32'(dut6.round_cnt), 0);
      check("t6_game_zero", 32'(dut6.game_cnt), 0);
      check("t6_target", 32'(g6.target), 1);
      g6.btn = 7'b0000001;
      step();
      g6.btn = '0;
      check("t6_hit", 32'(g6.hit_pulse), 1);
      check("t6_no_miss", {g6.miss_pulse, g6.misses}, 0);
      check("t6_score", 32'(g6.score), 1);
      check("t6_over", 32'(g6.game_over), 1);
      g6.start = 1'b1;
      step();
      g6.start = 1'b0;
      check("t6_restart_busy", 32'(g6.busy), 1);
      check("t6_restart_score", 32'(g6.score), 0);

      // Expire together with game end: miss counts, then OVER
      n = 0;
      do begin
         step();
         n++;
      end while (!g6.game_over && (n < 40));
      check("t6b_cycles", 32'(n), 10);
      check("t6b_miss_pulse", 32'(g6.miss_pulse), 1);
      check("t6b_misses", 32'(g6.misses), 1);
      check("t6b_score", 32'(g6.score), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
